// File: rtl/ling_mp_seq.sv
// Multi-precision add sequencer: streams 64-bit word pairs through an external
// Ling adder, chains the carry between words and registers each sum word.
module ling_mp_seq #(
  parameter int WIDTH     = 64,
  parameter int MAX_WORDS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic                         in_cin,
  output logic [WIDTH-1:0]             add_a,
  output logic [WIDTH-1:0]             add_b,
  output logic                         add_cin,
  output logic                         add_en,
  input  logic [WIDTH-1:0]             add_s,
  input  logic                         add_cout,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_sum,
  output logic [$clog2(MAX_WORDS)-1:0] out_idx,
  output logic                         out_last,
  output logic                         out_cout,
  output logic                         out_zero,
  output logic                         err
);

  localparam int IW = $clog2(MAX_WORDS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic          carry_q;
  logic [IW-1:0] idx_q;
  logic          zero_q;

  logic accept;
  logic restart;
  logic sum_zero;
  logic zero_next;
  logic overflow;
  logic word_last;
  logic proto_err;

  assign add_a    = in_a;
  assign add_b    = in_b;
  assign add_en   = 1'b1;
  assign in_ready = !out_valid || out_ready;

  // A word restarts the operand when we are idle or it claims to be first;
  // either way the carry comes from in_cin rather than the chained carry.
  always_comb begin
    accept    = in_valid && in_ready;
    restart   = (state == IDLE) || in_first;
    add_cin   = restart ? in_cin : carry_q;
    sum_zero  = (add_s == '0);
    zero_next = restart ? sum_zero : (zero_q & sum_zero);
    overflow  = !restart && (idx_q == IW'(MAX_WORDS - 1)) && !in_last;
    word_last = in_last || overflow;
    proto_err = (state == IDLE && !in_first) || (state == BUSY && in_first);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      zero_q    <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_zero  <= 1'b0;
      err       <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= add_s;
      out_last  <= word_last;
      out_idx   <= restart ? '0 : idx_q;
      idx_q     <= restart ? IW'(1) : idx_q + IW'(1);
      zero_q    <= zero_next;
      if (proto_err || overflow)
        err <= 1'b1;
      // The carry chain is broken at every operand boundary, forced or not.
      if (word_last) begin
        out_cout <= add_cout;
        out_zero <= zero_next;
        carry_q  <= 1'b0;
        state    <= IDLE;
      end else begin
        out_cout <= 1'b0;
        out_zero <= 1'b0;
        carry_q  <= add_cout;
        state    <= BUSY;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ling_mp_seq.sv
// Directed bench for ling_mp_seq; the Ling adder is modelled here as a plain
// 64-bit add so every expected sum is hand-computed from the operands.
module tb_ling_mp_seq;

  localparam int WIDTH     = 64;
  localparam int MAX_WORDS = 4;
  localparam int IW        = $clog2(MAX_WORDS);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             in_first, in_last, in_cin;
  logic [WIDTH-1:0] add_a, add_b, add_s;
  logic             add_cin, add_en, add_cout;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [IW-1:0]    out_idx;
  logic             out_last, out_cout, out_zero, err;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};

  ling_mp_seq #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_en(add_en),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last),
    .out_cout(out_cout), .out_zero(out_zero), .err(err)
  );

  typedef struct {
    logic [63:0] a, b;
    logic        first, last, cin;
    logic [63:0] sum;
    logic [IW-1:0] idx;
    logic        cout, zero;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents one word pair for exactly one rising edge; returns 1 time unit after it.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic first, input logic last, input logic cin);
    @(negedge clk);
    in_a = a; in_b = b; in_first = first; in_last = last; in_cin = cin;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic checkWord(input string tag, input logic [63:0] sum, input logic [IW-1:0] idx,
                           input logic last, input logic cout, input logic zero);
    checkOutput({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
    checkOutput({tag, ".sum"}, out_sum, sum);
    checkOutput({tag, ".idx"}, {{(64-IW){1'b0}}, out_idx}, {{(64-IW){1'b0}}, idx});
    checkOutput({tag, ".last"}, {63'd0, out_last}, {63'd0, last});
    if (last) begin
      checkOutput({tag, ".cout"}, {63'd0, out_cout}, {63'd0, cout});
      checkOutput({tag, ".zero"}, {63'd0, out_zero}, {63'd0, zero});
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    //        a                       b                      f     l     cin   sum                     idx cout  zero
    vecs[0] = '{ONES,                 64'd1,                 1'b1, 1'b1, 1'b0, 64'd0,                  2'd0, 1'b1, 1'b1};
    vecs[1] = '{ONES,                 64'd0,                 1'b1, 1'b0, 1'b1, 64'd0,                  2'd0, 1'b0, 1'b0};
    vecs[2] = '{64'd0,                64'd0,                 1'b0, 1'b1, 1'b0, 64'd1,                  2'd1, 1'b0, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 64'd0,            2'd0, 1'b0, 1'b0};
    vecs[4] = '{64'd1,                64'd2,                 1'b0, 1'b0, 1'b0, 64'd4,                  2'd1, 1'b0, 1'b0};
    vecs[5] = '{ONES,                 ONES,                  1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 2'd2, 1'b1, 1'b0};
    vecs[6] = '{64'd5,                64'd7,                 1'b1, 1'b1, 1'b1, 64'd13,                 2'd0, 1'b0, 1'b0};
    vecs[7] = '{64'd0,                64'd0,                 1'b1, 1'b0, 1'b0, 64'd0,                  2'd0, 1'b0, 1'b0};
    vecs[8] = '{64'd0,                64'd0,                 1'b0, 1'b1, 1'b0, 64'd0,                  2'd1, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_first = 1'b0; in_last = 1'b0; in_cin = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst.valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst.sum", out_sum, 64'd0);
    checkOutput("rst.last", {63'd0, out_last}, 64'd0);
    checkOutput("rst.err", {63'd0, err}, 64'd0);
    checkOutput("rst.in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].first, vecs[i].last, vecs[i].cin);
      checkWord($sformatf("vec%0d", i), vecs[i].sum, vecs[i].idx, vecs[i].last, vecs[i].cout, vecs[i].zero);
    end
    checkOutput("table.err", {63'd0, err}, 64'd0);
    @(posedge clk); #1;
    checkOutput("idle.valid", {63'd0, out_valid}, 64'd0);

    // Backpressure: three words, downstream stalled after the first.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(64'd10, 64'd1, 1'b1, 1'b0, 1'b0);
    checkWord("bp0", 64'd11, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp.in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    in_a = 64'd20; in_b = 64'd2; in_first = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkWord("bp.hold", 64'd11, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp.in_ready2", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkWord("bp1", 64'd22, 2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(64'd30, 64'd3, 1'b0, 1'b1, 1'b0);
    checkWord("bp2", 64'd33, 2'd2, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkOutput("bp.drain", {63'd0, out_valid}, 64'd0);
    checkOutput("bp.err", {63'd0, err}, 64'd0);

    // in_first mid-operand: new operand must ignore the pending chained carry.
    applyStimulus(ONES, 64'd1, 1'b1, 1'b0, 1'b0);
    checkWord("pe0", 64'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("pe0.err", {63'd0, err}, 64'd0);
    applyStimulus(64'd3, 64'd4, 1'b1, 1'b1, 1'b0);
    checkWord("pe1", 64'd7, 2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("pe1.err", {63'd0, err}, 64'd1);

    doReset();
    checkOutput("rst2.err", {63'd0, err}, 64'd0);
    applyStimulus(64'd5, 64'd5, 1'b0, 1'b1, 1'b1);
    checkWord("nf", 64'd11, 2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("nf.err", {63'd0, err}, 64'd1);

    // Overflow at MAX_WORDS words without in_last.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(64'(i), 64'd0, (i == 0), 1'b0, 1'b0);
      checkWord($sformatf("ov%0d", i), 64'(i), IW'(i), (i == 3), 1'b0, 1'b0);
      checkOutput($sformatf("ov%0d.err", i), {63'd0, err}, {63'd0, (i == 3)});
    end
    applyStimulus(64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    checkWord("ov.idle", 64'd1, 2'd0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between words 2 and 3.
    doReset();
    applyStimulus(ONES, 64'd1, 1'b1, 1'b0, 1'b0);
    checkWord("ar0", 64'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(64'd1, 64'd1, 1'b0, 1'b0, 1'b0);
    checkWord("ar1", 64'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar.valid", {63'd0, out_valid}, 64'd0);
    checkOutput("ar.idx", {{(64-IW){1'b0}}, out_idx}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(64'd2, 64'd2, 1'b1, 1'b1, 1'b0);
    checkWord("ar2", 64'd4, 2'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("ar.err", {63'd0, err}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ling_mp_seq.md
Name: ling_mp_seq

Overview:
Multi-precision add sequencer wrapped around the 64-bit Ling adder.
- Accepts long operands as a stream of 64-bit word pairs, least-significant word first, over a valid/ready handshake.
- Drives each word pair into the adder and chains the carry between words.
- Registers each sum word and presents it downstream with valid/ready, plus end-of-operand carry, zero and error flags.

Parameters:
WIDTH, 64, word width; must match the adder width.
MAX_WORDS, 16, maximum words per operand; the word index counter is clog2(MAX_WORDS) bits wide.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous and active-low.
in_valid  in  1  input word pair valid.
in_ready  out  1  sequencer can accept a word pair this cycle.
in_a  in  WIDTH  operand A word.
in_b  in  WIDTH  operand B word.
in_first  in  1  this word is the least-significant word of a new operand.
in_last  in  1  this word is the most-significant word of the operand.
in_cin  in  1  carry-in for the operand; used only with in_first.
add_a  out  WIDTH  to adder ain.
add_b  out  WIDTH  to adder bin.
add_cin  out  1  to adder cin.
add_en  out  1  to adder enable; tied to 1.
add_s  in  WIDTH  from adder s.
add_cout  in  1  from adder cout.
out_valid  out  1  registered sum word valid.
out_ready  in  1  downstream accepts the sum word.
out_sum  out  WIDTH  sum word.
out_idx  out  clog2(MAX_WORDS)  word index within the operand; 0 for the first word.
out_last  out  1  final word of the operand.
out_cout  out  1  carry-out of the operand; meaningful only when out_last=1.
out_zero  out  1  all sum words of the operand are zero; meaningful only when out_last=1.
err  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_sum=0, out_idx=0, out_last=0, out_cout=0, out_zero=0, err=0, carry_q=0, idx_q=0, zero_q=1, state=IDLE.
- Reset mid-operand discards the partial result; nothing is emitted.
- Adder interface:
  - add_a=in_a and add_b=in_b, combinationally.
  - add_cin = in_first ? in_cin : carry_q (IDLE also uses in_cin).
  - add_s/add_cout are settled before the next rising edge and are sampled there.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept = in_valid && in_ready.
  - On accept, in the same edge: out_sum<=add_s; out_valid<=1; carry_q<=add_cout.
  - Latency is 1 cycle, accept to out_valid.
  - Throughput is 1 word/cycle while out_ready=1.
  - Without accept, if out_ready=1 then out_valid<=0; otherwise all out_* hold.
- States:
  - IDLE: waiting for the first word.
  - BUSY: mid-operand.
- IDLE, accept:
  - out_idx<=0; idx_q<=1.
  - zero_q <= (add_s==0).
  - If in_first=0, treat the word as first (use in_cin) and set err.
  - in_last=1: emit out_last=1, stay IDLE. Otherwise go to BUSY.
- BUSY, accept with in_first=0:
  - out_idx<=idx_q; idx_q++.
  - zero_q &= (add_s==0).
  - in_last=1: out_last=1, go to IDLE.
- BUSY, accept with in_first=1:
  - Set err; the previous operand is abandoned with no out_last ever emitted for it.
  - The word is handled as the first word of a new operand (IDLE rules).
- Overflow: when idx_q==MAX_WORDS-1 and the accepted word has in_last=0:
  - Force out_last=1, set err, go to IDLE.
- On any out_last word:
  - out_cout=add_cout.
  - out_zero = zero_q_next.
  - carry_q is cleared.
- in_valid is ignored while in_ready=0. The upstream must hold its data stable; this is not checked.

Test Plan:
1. Single word: in_first=in_last=1, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → next cycle out_valid=1, out_sum=0, out_cout=1, out_zero=1, out_last=1, out_idx=0.
2. Two-word carry chain: words (a,b) = (all-ones, 0) then (0, 0), cin=1 → sums 0 then 1; out_cout=0; out_zero=0; out_idx 0 then 1.
3. Backpressure: hold out_ready=0 while streaming 3 words → in_ready drops after the first accept; out_sum holds; releasing out_ready delivers all 3 words in order with no loss or duplicate.
4. Protocol errors:
   - in_first=1 mid-operand → err=1; the new operand computes correctly from in_cin.
   - A first word with in_first=0 → err=1 and the sum uses in_cin.
5. Overflow: MAX_WORDS=4, stream 4 words with no in_last → 4th word has out_last=1 and out_idx=3; err=1; state returns to IDLE.
6. Reset mid-operand: assert rst_n=0 asynchronously between words 2 and 3 → out_valid drops immediately; the next operand starts with out_idx=0 and uses in_cin.
